demulti_12: RTL and testbench
=============================

Name: demulti_12

Overview:
- Registered 1-to-N demultiplexer; default configuration is 1-bit data, 2 output lanes.
- Routes input `d` to the lane chosen by `select`. Every other lane is driven to zero.
- Used as a simple steering element in datapaths.
- Outputs are registered with one-cycle latency, on a single clock domain.

Parameters:
- DATA_W, 1, width of the data input and of each output lane.
- NUM_OUT, 2, number of output lanes (legal range 2..16).
- SEL_W, $clog2(NUM_OUT), width of `select`; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  DATA_W  data to route.
- select  input  SEL_W  destination lane index.
- in_valid  input  1  qualifies `d` and `select` this cycle.
- q  output  DATA_W*NUM_OUT  flat lane bus; lane i occupies bits [i*DATA_W +: DATA_W].
- q_valid  output  NUM_OUT  one-hot; bit i high when lane i carries routed data.
- sel_err  output  1  one-cycle pulse when `select` >= NUM_OUT while `in_valid` is high.

Behaviour:
- Reset: on a rising edge of clk with rst=1, q, q_valid and sel_err all go to 0. rst takes priority over all inputs.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N and hold until edge N+1.
- Routing, when `in_valid`=1 and `select` < NUM_OUT:
  - lane[select] gets `d`.
  - All other lanes get 0.
  - q_valid gets the one-hot of `select`.
  - sel_err gets 0.
- When `in_valid`=0:
  - All lanes of q go to 0 and q_valid goes to 0 on the next edge. There is no hold of previous data.
  - sel_err goes to 0.
- Out-of-range `select` with `in_valid`=1: only possible when NUM_OUT is not a power of 2.
  - q goes to all zeros, q_valid to 0, and sel_err to 1 for that cycle.
- Routing truth table, default params, `in_valid`=1:
  - d=0, sel=0 -> q=2'b00, q_valid=2'b01.
  - d=0, sel=1 -> q=2'b00, q_valid=2'b10.
  - d=1, sel=0 -> q=2'b01, q_valid=2'b01.
  - d=1, sel=1 -> q=2'b10, q_valid=2'b10.
- d=0 on a selected lane is valid data: q stays zero but q_valid still marks the lane.
- Back-to-back: a new routing is accepted every cycle with no bubbles. Changing `select` every cycle moves data between lanes cycle by cycle.
- Reset asserted mid-stream: outputs clear on the same edge. The first input after reset deasserts appears one cycle later.
- Unknown or X on `select` while `in_valid`=0 must not affect the outputs.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - the lane-slice helper (index i -> bit offset i*DATA_W);
  - the one-hot encode function (SEL_W -> NUM_OUT).
- One natural sub-module, demux_lane: per-lane gating of `d` by a one-hot enable.
  - Instantiated NUM_OUT times via generate.
  - The top level owns the output registers and sel_err.

Test Plan:
- Reset: drive d=1, sel=1, in_valid=1 with rst=1 for 2 cycles -> q=00, q_valid=00, sel_err=0. After rst drops, next edge -> q=10.
- Truth table (default params, in_valid=1): sequence d/sel = 0/0, 0/1, 1/0, 1/1 -> q = 00, 00, 01, 10 one cycle later each; q_valid = 01, 10, 01, 10.
- Valid gating: d=1, sel=0, in_valid=0 -> q=00, q_valid=00. Set in_valid=1 -> q=01 next cycle.
- Back-to-back toggle: d=1, sel alternating 0,1,0,1 every cycle -> q alternates 01, 10, 01, 10 with no gap.
- Out of range (NUM_OUT=3, DATA_W=4): d=4'hA, sel=3, in_valid=1 -> q=0, q_valid=000, sel_err=1 for one cycle. Then sel=2 -> q=12'hA00, q_valid=100, sel_err=0.
- Mid-stream reset: streaming d=1/sel=1, assert rst for one cycle -> outputs 0 on that edge, resume 10 one cycle after rst deasserts.

Source files
------------

// File: rtl/demulti_12_pkg.sv
// Shared helpers for the demulti_12 demultiplexer: lane slicing and one-hot encoding.
package demulti_12_pkg;

  localparam int unsigned MaxOut  = 16;
  localparam int unsigned MaxSelW = 4;

  typedef logic [MaxOut-1:0]  lane_mask_t;
  typedef logic [MaxSelW-1:0] sel_ext_t;

  // Bit offset of lane idx within the flat output bus.
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned data_w);
    return idx * data_w;
  endfunction

  function automatic lane_mask_t onehot_enc(input sel_ext_t sel);
    lane_mask_t oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demulti_12_lane.sv
// Single output lane: passes d through when its one-hot enable is set, zero otherwise.
module demux_lane #(
  parameter int unsigned DATA_W = 1
) (
  input  logic [DATA_W-1:0] d,
  input  logic              en,
  output logic [DATA_W-1:0] lane
);

  always_comb begin
    lane = en ? d : '0;
  end

endmodule

// File: rtl/demulti_12.sv
// Registered 1-to-N demultiplexer; unselected lanes are zero, out-of-range select flags sel_err.
module demulti_12
  import demulti_12_pkg::*;
#(
  parameter int unsigned DATA_W  = 1,
  parameter int unsigned NUM_OUT = 2,
  localparam int unsigned SEL_W  = $clog2(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         d,
  input  logic [SEL_W-1:0]          select,
  input  logic                      in_valid,
  output logic [DATA_W*NUM_OUT-1:0] q,
  output logic [NUM_OUT-1:0]        q_valid,
  output logic                      sel_err
);

  sel_ext_t                  sel_ext;
  lane_mask_t                sel_oh;
  logic                      in_range;
  logic [NUM_OUT-1:0]        lane_en;
  logic [DATA_W*NUM_OUT-1:0] q_d, q_q;
  logic [NUM_OUT-1:0]        q_valid_q;
  logic                      sel_err_d, sel_err_q;

  // in_valid gates everything, so an X select while idle cannot leak into state.
  always_comb begin
    sel_ext              = '0;
    sel_ext[SEL_W-1:0]   = select;
    in_range             = (32'(sel_ext) < NUM_OUT);
    sel_oh               = onehot_enc(sel_ext);
    lane_en              = '0;
    if (in_valid && in_range) begin
      lane_en = sel_oh[NUM_OUT-1:0];
    end
    sel_err_d = in_valid && !in_range;
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
    demux_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .d    (d),
      .en   (lane_en[i]),
      .lane (q_d[lane_lsb(i, DATA_W) +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= '0;
      q_valid_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      q_valid_q <= lane_en;
      sel_err_q <= sel_err_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_demulti_12.sv
// Bench for demulti_12: default 1x2 instance plus a 4-bit x 3-lane instance, directed then random.
module tb_demulti_12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // Default configuration: DATA_W=1, NUM_OUT=2.
  logic       d2 = 1'b0;
  logic       sel2 = 1'b0;
  logic       v2 = 1'b0;
  logic [1:0] q2;
  logic [1:0] qv2;
  logic       err2;

  // Non-power-of-2 configuration: DATA_W=4, NUM_OUT=3.
  logic [3:0]  d3 = '0;
  logic [1:0]  sel3 = '0;
  logic        v3 = 1'b0;
  logic [11:0] q3;
  logic [2:0]  qv3;
  logic        err3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demulti_12 dut2 (
    .clk      (clk),
    .rst      (rst),
    .d        (d2),
    .select   (sel2),
    .in_valid (v2),
    .q        (q2),
    .q_valid  (qv2),
    .sel_err  (err2)
  );

  demulti_12 #(
    .DATA_W  (4),
    .NUM_OUT (3)
  ) dut3 (
    .clk      (clk),
    .rst      (rst),
    .d        (d3),
    .select   (sel3),
    .in_valid (v3),
    .q        (q3),
    .q_valid  (qv3),
    .sel_err  (err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: data lands at bit offset sel*w when accepted, everything else reads zero.
  function automatic logic [31:0] model_q(input int unsigned w, input int unsigned n,
                                          input logic [31:0] dv, input logic [31:0] sv,
                                          input logic v, input logic r);
    if (r || !v) return 32'd0;
    if (sv >= n) return 32'd0;
    return dv << (sv * w);
  endfunction

  function automatic logic [31:0] model_qv(input int unsigned n, input logic [31:0] sv,
                                           input logic v, input logic r);
    if (r || !v) return 32'd0;
    if (sv >= n) return 32'd0;
    return 32'd1 << sv;
  endfunction

  function automatic logic [31:0] model_err(input int unsigned n, input logic [31:0] sv,
                                            input logic v, input logic r);
    if (r || !v) return 32'd0;
    return (sv >= n) ? 32'd1 : 32'd0;
  endfunction

  // One clock edge with current inputs, then compare all outputs of both instances.
  task automatic cycle(input string tag);
    @(posedge clk);
    #1;
    check({tag, ".q2"},   32'(q2),   model_q(1, 2, 32'(d2), 32'(sel2), v2, rst));
    check({tag, ".qv2"},  32'(qv2),  model_qv(2, 32'(sel2), v2, rst));
    check({tag, ".err2"}, 32'(err2), model_err(2, 32'(sel2), v2, rst));
    check({tag, ".q3"},   32'(q3),   model_q(4, 3, 32'(d3), 32'(sel3), v3, rst));
    check({tag, ".qv3"},  32'(qv3),  model_qv(3, 32'(sel3), v3, rst));
    check({tag, ".err3"}, 32'(err3), model_err(3, 32'(sel3), v3, rst));
  endtask

  initial begin
    // Reset held with active inputs.
    rst = 1'b1; d2 = 1'b1; sel2 = 1'b1; v2 = 1'b1;
    d3 = 4'hA; sel3 = 2'd3; v3 = 1'b1;
    cycle("rst0");
    cycle("rst1");
    rst = 1'b0;
    cycle("rst_exit");
    check("rst_exit.lit_q2", 32'(q2), 32'h2);

    // Truth table on the default instance.
    for (int i = 0; i < 4; i++) begin
      d2 = i[1]; sel2 = i[0]; v2 = 1'b1;
      cycle("truth");
    end
    check("truth.lit_q2", 32'(q2), 32'h2);
    check("truth.lit_qv2", 32'(qv2), 32'h2);

    // Valid gating, including X select while idle.
    d2 = 1'b1; sel2 = 1'b0; v2 = 1'b0;
    cycle("gate_off");
    sel2 = 1'bx; sel3 = 2'bxx; v3 = 1'b0;
    cycle("gate_x");
    sel2 = 1'b0; sel3 = 2'd0; v2 = 1'b1;
    cycle("gate_on");
    check("gate_on.lit_q2", 32'(q2), 32'h1);

    // Back-to-back lane toggling.
    for (int i = 0; i < 4; i++) begin
      d2 = 1'b1; sel2 = i[0]; v2 = 1'b1;
      cycle("toggle");
    end

    // Out-of-range select on the 3-lane instance, then a legal one.
    d3 = 4'hA; sel3 = 2'd3; v3 = 1'b1;
    cycle("oor");
    check("oor.lit_err3", 32'(err3), 32'h1);
    sel3 = 2'd2;
    cycle("oor_next");
    check("oor_next.lit_q3", 32'(q3), 32'hA00);
    check("oor_next.lit_qv3", 32'(qv3), 32'h4);

    // Mid-stream reset.
    d2 = 1'b1; sel2 = 1'b1; v2 = 1'b1;
    cycle("stream");
    rst = 1'b1;
    cycle("mid_rst");
    rst = 1'b0;
    cycle("resume");
    check("resume.lit_q2", 32'(q2), 32'h2);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rst  = ($urandom_range(0, 19) == 0);
      d2   = 1'($urandom);
      sel2 = 1'($urandom);
      v2   = ($urandom_range(0, 3) != 0);
      d3   = 4'($urandom);
      sel3 = 2'($urandom_range(0, 3));
      v3   = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
